d_pipe_reg_amisha: RTL

- Parametrised, enable-gated register pipeline with per-stage valid tracking. It generalises the single D flip-flop to a WIDTH-bit, DEPTH-stage delay line.
- Adds async reset, synchronous flush, a runtime-selectable tap and an occupancy counter.
- Used wherever datapaths need balanced, stallable delay: operand alignment, retiming and sample delay lines.

---
 rtl/d_pipe_reg_amisha.sv | 95 +++++++++
 1 files changed

// File: rtl/d_pipe_reg_amisha.sv
// d_pipe_reg_amisha: WIDTH x DEPTH enable-gated delay line with per-stage valid, flush, tap and occupancy.
// Define D_PIPE_PARITY_EN to carry a per-stage parity bit and drive the sticky perr_amisha flag.
module d_pipe_reg_amisha #(
    parameter int               WIDTH   = 8,
    parameter int               DEPTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    localparam int              TW      = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int              OW      = $clog2(DEPTH + 1)
) (
    input  logic             clk_amisha,
    input  logic             rst_amisha,
    input  logic             en_amisha,
    input  logic             clr_amisha,
    input  logic [WIDTH-1:0] d_amisha,
    input  logic             d_valid_amisha,
    input  logic             inj_amisha,
    input  logic [TW-1:0]    tap_sel_amisha,
    output logic [WIDTH-1:0] q_amisha,
    output logic             q_valid_amisha,
    output logic [WIDTH-1:0] tap_q_amisha,
    output logic             tap_valid_amisha,
    output logic [OW-1:0]    occ_amisha,
    output logic             perr_amisha
);

    logic [WIDTH-1:0] stage_r [DEPTH];
    logic [DEPTH-1:0] valid_r;
    logic [OW-1:0]    occ_r;

    always_ff @(posedge clk_amisha or posedge rst_amisha) begin
        if (rst_amisha) begin
            for (int i = 0; i < DEPTH; i++) stage_r[i] <= RST_VAL;
            valid_r <= '0;
            occ_r   <= '0;
        end else if (clr_amisha) begin
            for (int i = 0; i < DEPTH; i++) stage_r[i] <= RST_VAL;
            valid_r <= '0;
            occ_r   <= '0;
        end else if (en_amisha) begin
            stage_r[0] <= d_amisha;
            valid_r[0] <= d_valid_amisha;
            for (int i = 1; i < DEPTH; i++) begin
                stage_r[i] <= stage_r[i-1];
                valid_r[i] <= valid_r[i-1];
            end
            // Incremental update: one may enter and one may leave per advance.
            occ_r <= occ_r + OW'(d_valid_amisha) - OW'(valid_r[DEPTH-1]);
        end
    end

    assign q_amisha       = stage_r[DEPTH-1];
    assign q_valid_amisha = valid_r[DEPTH-1];
    assign occ_amisha     = occ_r;

    // Out-of-range selects (non power-of-2 DEPTH) fall through to the defaults.
    always_comb begin
        tap_q_amisha     = RST_VAL;
        tap_valid_amisha = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (int'(tap_sel_amisha) == i) begin
                tap_q_amisha     = stage_r[i];
                tap_valid_amisha = valid_r[i];
            end
        end
    end

`ifdef D_PIPE_PARITY_EN
    logic [DEPTH-1:0] par_r;
    logic             perr_r;

    always_ff @(posedge clk_amisha or posedge rst_amisha) begin
        if (rst_amisha) begin
            par_r  <= {DEPTH{^RST_VAL}};
            perr_r <= 1'b0;
        end else if (clr_amisha) begin
            par_r  <= {DEPTH{^RST_VAL}};
            perr_r <= 1'b0;
        end else begin
            if (en_amisha) begin
                par_r[0] <= (^d_amisha) ^ inj_amisha;
                for (int i = 1; i < DEPTH; i++) par_r[i] <= par_r[i-1];
            end
            if (valid_r[DEPTH-1] && ((^stage_r[DEPTH-1]) != par_r[DEPTH-1]))
                perr_r <= 1'b1;
        end
    end

    assign perr_amisha = perr_r;
`else
    logic unused_inj;
    assign unused_inj  = inj_amisha;
    assign perr_amisha = 1'b0;
`endif

endmodule
